muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage of the pipelined core, alongside the ALU. It accepts one M-extension operation at a time, sequences a 32-step shift-add multiply or restoring divide, and stalls the pipeline until the result is ready. It also handles the RISC-V divide-by-zero and signed-overflow corner cases without iterating.

---
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_muldiv_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Divide-by-zero and signed overflow finish in one cycle without iterating.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] SignMin = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              a_sgn, b_sgn, is_div, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] mul_next, div_next, prod_n;
    logic [XLEN-1:0]   quot_n, rem_n, fin;

    // Operand signedness by op: a is signed for mul/mulh/mulhsu/div/rem, b for mul/mulh/div/rem.
    always_comb begin
        is_div   = funct3[2];
        a_sgn    = src_a[XLEN-1] & (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110});
        b_sgn    = src_b[XLEN-1] & (funct3 inside {3'b000, 3'b001, 3'b100, 3'b110});
        a_mag    = a_sgn ? (~src_a + 1'b1) : src_a;
        b_mag    = b_sgn ? (~src_b + 1'b1) : src_b;
        div_zero = is_div && (src_b == '0);
        div_ovf  = is_div && !funct3[0] && (src_a == SignMin) && (src_b == '1);
    end

    // Multiply step keeps the multiplier in the low half and shifts the partial sum in from above.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
        div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                    : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    always_comb begin
        prod_n = neg_q ? (~acc_q + 1'b1) : acc_q;
        quot_n = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_n  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        if (op_q[2]) begin
            fin = op_q[1] ? rem_n : quot_n;
        end else begin
            fin = (op_q[1:0] == 2'b00) ? prod_n[XLEN-1:0] : prod_n[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        res_d   = res_q;
        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    op_d  = funct3;
                    neg_d = (funct3[2] & funct3[1]) ? a_sgn : (a_sgn ^ b_sgn);
                    cnt_d = '0;
                    // Corner cases preload {remainder, quotient} with no sign fix-up.
                    if (div_zero) begin
                        acc_d   = {src_a, {XLEN{1'b1}}};
                        neg_d   = 1'b0;
                        state_d = StDone;
                    end else if (div_ovf) begin
                        acc_d   = {{XLEN{1'b0}}, SignMin};
                        neg_d   = 1'b0;
                        state_d = StDone;
                    end else begin
                        opnd_d  = is_div ? b_mag : a_mag;
                        acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                if (!flush) begin
                    res_d = fin;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    // The DONE-cycle result is forwarded so EX can capture it while done is high.
    always_comb begin
        busy   = (state_q != StIdle);
        stall  = (start && (state_q == StIdle) && !flush) || (state_q == StCalc);
        done   = (state_q == StDone) && !flush;
        result = done ? fin : res_q;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected results, latency and stall checks.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        busy, stall, done;
    logic [31:0] result;

    int unsigned total = 0;
    int unsigned bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res = '0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .src_a(src_a),
        .src_b(src_b), .flush(flush), .busy(busy), .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, b);
        logic [63:0] ea, eb, p;
        int sa, sb;
        sa = a;
        sb = b;
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        case (f)
            3'b000: begin p = ea * eb; return p[31:0]; end
            3'b001: begin p = ea * eb; return p[63:32]; end
            3'b010: begin p = ea * {32'b0, b}; return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Caller is positioned just after a rising edge with the unit idle.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, b, input logic [31:0] exp_v);
        int lat, n;
        logic [31:0] e;
        lat = (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
        start = 1'b1; funct3 = f; src_a = a; src_b = b;
        exp_q.push_back(exp_v);
        @(negedge clk);
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL stall_issue f=%0d got=%b want=1", f, stall); end
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        forever begin
            @(negedge clk);
            if (done === 1'b1) break;
            total++;
            if (stall !== 1'b1) begin bad++; $display("FAIL stall_calc cyc=%0d got=%b want=1", n, stall); end
            n++;
            if (n > 40) break;
        end
        e = exp_q.pop_front();
        total++;
        if (n !== lat) begin bad++; $display("FAIL latency f=%0d got=%0d want=%0d", f, n, lat); end
        total++;
        if (result !== e) begin
            bad++; $display("FAIL result f=%0d a=%h b=%h got=%h want=%h", f, a, b, result, e);
        end
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL stall_done got=%b want=0", stall); end
        last_res = e;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL idle_after busy=%b done=%b want=0,0", busy, done);
        end
        total++;
        if (result !== e) begin bad++; $display("FAIL result_hold got=%h want=%h", result, e); end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({busy, stall, done, result} !== 35'b0) begin
            bad++; $display("FAIL reset busy=%b stall=%b done=%b result=%h want all 0",
                            busy, stall, done, result);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask

    task automatic test_div();
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        issue(3'b101, 32'd100, 32'd7, 32'd14);
        issue(3'b111, 32'd100, 32'd7, 32'd2);
        issue(3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1);
        issue(3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE);
    endtask

    task automatic test_corner();
        issue(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
        issue(3'b110, 32'd5, 32'd0, 32'd5);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        issue(3'b111, 32'h1234_5678, 32'd0, 32'h1234_5678);
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            f = 3'($urandom_range(0, 7));
            a = (i % 4 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            issue(f, a, b, model(f, a, b));
        end
    endtask

    task automatic test_flush();
        int seen;
        seen = 0;
        start = 1'b1; funct3 = 3'b100; src_a = 32'd1000; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        if (done === 1'b1) seen++;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle busy=%b want=0", busy); end
        total++;
        if (seen != 0) begin bad++; $display("FAIL flush_no_done pulses=%0d want=0", seen); end
        total++;
        if (result !== last_res) begin
            bad++; $display("FAIL flush_result got=%h want=%h", result, last_res);
        end
        @(posedge clk); #1;
        issue(3'b101, 32'd1000, 32'd3, 32'd333);
        // start together with flush in IDLE must be dropped
        start = 1'b1; flush = 1'b1; funct3 = 3'b000; src_a = 32'd2; src_b = 32'd3;
        @(negedge clk);
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL flush_start_stall got=%b want=0", stall); end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL flush_start_busy got=%b want=0", busy); end
    endtask

    task automatic test_rst_mid();
        int seen;
        seen = 0;
        start = 1'b1; funct3 = 3'b000; src_a = 32'd9; src_b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, stall, done, result} !== 35'b0) begin
            bad++; $display("FAIL rst_mid busy=%b stall=%b done=%b result=%h want all 0",
                            busy, stall, done, result);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        last_res = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL rst_no_done pulses=%0d want=0", seen); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_busy();
        int n;
        n = 1;
        start = 1'b1; funct3 = 3'b000; src_a = 32'd6; src_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        forever begin
            start = (n == 5);
            funct3 = (n == 5) ? 3'b011 : 3'b000;
            src_a = (n == 5) ? 32'hFFFF_FFFF : 32'd6;
            @(negedge clk);
            if (done === 1'b1) break;
            n++;
            if (n > 40) break;
        end
        start = 1'b0;
        total++;
        if (n !== 33) begin bad++; $display("FAIL busy_start_latency got=%0d want=33", n); end
        total++;
        if (result !== 32'd42) begin bad++; $display("FAIL busy_start_result got=%h want=2a", result); end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL busy_start_idle got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back();
        issue(3'b000, 32'hDEAD_BEEF, 32'h0000_0010, 32'hEADB_EEF0);
        issue(3'b100, 32'd42, 32'd0, 32'hFFFF_FFFF);
        issue(3'b110, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_corner();
        test_random();
        test_flush();
        test_rst_mid();
        test_start_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
